// File: rtl/dwt97_line_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dwt97_line_sequencer: wraps each input line in symmetric extension for   |
// | the 9/7 lifting unit. Optional stall counter: define DWT_SEQ_PERF_EN.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dwt97_line_sequencer #(
  parameter int DataWidth       = 16,
  parameter int MaximumSideSize = 512,
  parameter int ExtPairs        = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 cfg_start_i,
  input  logic [$clog2(MaximumSideSize/2):0]   cfg_pairs_i,
  input  logic [$clog2(MaximumSideSize):0]     cfg_lines_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o,
`ifdef DWT_SEQ_PERF_EN
  output logic [31:0]                          perf_stall_o,
`endif
  output logic                                 s_ready_o,
  input  logic                                 s_valid_i,
  input  logic [2*DataWidth-1:0]               s_data_i,
  input  logic                                 m_ready_i,
  output logic                                 m_valid_o,
  output logic                                 m_sof_o,
  output logic                                 m_eol_o,
  output logic [2*DataWidth-1:0]               m_data_o
);

  localparam int c_PW = $clog2(MaximumSideSize/2) + 1;
  localparam int c_LW = $clog2(MaximumSideSize) + 1;
  localparam int c_BW = 2 * DataWidth;
  localparam int c_IW = $clog2(ExtPairs + 1);

  localparam logic [c_IW-1:0] c_E_IDX   = c_IW'(ExtPairs);
  localparam logic [c_IW-1:0] c_ONE_I   = c_IW'(1);
  localparam logic [c_PW-1:0] c_ONE_P   = c_PW'(1);
  localparam logic [c_PW-1:0] c_E_P     = c_PW'(ExtPairs);
  localparam logic [c_PW-1:0] c_E_M1_P  = c_PW'(ExtPairs - 1);
  localparam logic [c_PW-1:0] c_MIN_P   = c_PW'(ExtPairs + 1);
  localparam logic [c_PW-1:0] c_MAX_P   = c_PW'(MaximumSideSize / 2);
  localparam logic [c_LW-1:0] c_ONE_L   = c_LW'(1);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_FILL = 3'd1;
  localparam logic [2:0] c_PRE  = 3'd2;
  localparam logic [2:0] c_HEAD = 3'd3;
  localparam logic [2:0] c_PASS = 3'd4;
  localparam logic [2:0] c_POST = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [c_PW-1:0] pairs_q, pairs_d, cnt_q, cnt_d;
  logic [c_LW-1:0] lines_q, lines_d, line_q, line_d;
  logic [c_BW-1:0] hist_q [ExtPairs+1];
  logic [c_BW-1:0] hist_d [ExtPairs+1];
  logic            err_q, err_d, done_q, done_d;

  logic            w_m_valid, w_fire, w_cfg_bad, w_last_line;
  logic [c_IW-1:0] w_idx, w_odd_idx, w_even_idx;
  logic [c_BW-1:0] w_mirror;

  // PRE and POST share the same mirror indexing: odd from H[E-1-cnt], even from H[E-cnt].
  assign w_idx       = cnt_q[c_IW-1:0];
  assign w_even_idx  = c_E_IDX - w_idx;
  assign w_odd_idx   = w_even_idx - c_ONE_I;
  assign w_mirror    = {hist_q[w_odd_idx][c_BW-1:DataWidth], hist_q[w_even_idx][DataWidth-1:0]};
  assign w_cfg_bad   = (cfg_pairs_i < c_MIN_P) || (cfg_lines_i == '0) || (cfg_pairs_i > c_MAX_P);
  assign w_last_line = (line_q == lines_q - c_ONE_L);
  assign w_fire      = w_m_valid & m_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= c_IDLE;
      pairs_q <= '0;
      lines_q <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i <= ExtPairs; i++) hist_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pairs_q <= pairs_d;
      lines_q <= lines_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      hist_q  <= hist_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pairs_d = pairs_q;
    lines_d = lines_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    hist_d  = hist_q;
    case (state_q)
      c_IDLE: if (cfg_start_i) begin
        if (w_cfg_bad) begin
          err_d = 1'b1;
        end else begin
          pairs_d = cfg_pairs_i;
          lines_d = cfg_lines_i;
          err_d   = 1'b0;
          line_d  = '0;
          cnt_d   = '0;
          state_d = c_FILL;
        end
      end
      c_FILL: if (s_valid_i) begin
        hist_d[w_idx] = s_data_i;
        if (cnt_q == c_E_P) begin
          cnt_d   = '0;
          state_d = c_PRE;
        end else begin
          cnt_d = cnt_q + c_ONE_P;
        end
      end
      c_PRE: if (w_fire) begin
        if (cnt_q == c_E_M1_P) begin
          cnt_d   = '0;
          state_d = c_HEAD;
        end else begin
          cnt_d = cnt_q + c_ONE_P;
        end
      end
      c_HEAD: if (w_fire) begin
        if (cnt_q == c_E_P) begin
          // In PASS the counter tracks the absolute pair index of the line.
          if (pairs_q > c_MIN_P) begin
            cnt_d   = c_MIN_P;
            state_d = c_PASS;
          end else begin
            cnt_d   = '0;
            state_d = c_POST;
          end
        end else begin
          cnt_d = cnt_q + c_ONE_P;
        end
      end
      c_PASS: if (w_fire) begin
        for (int i = 0; i < ExtPairs; i++) hist_d[i] = hist_q[i+1];
        hist_d[ExtPairs] = s_data_i;
        if (cnt_q == pairs_q - c_ONE_P) begin
          cnt_d   = '0;
          state_d = c_POST;
        end else begin
          cnt_d = cnt_q + c_ONE_P;
        end
      end
      c_POST: if (w_fire) begin
        if (cnt_q == c_E_M1_P) begin
          cnt_d = '0;
          if (w_last_line) begin
            done_d  = 1'b1;
            state_d = c_IDLE;
          end else begin
            line_d  = line_q + c_ONE_L;
            state_d = c_FILL;
          end
        end else begin
          cnt_d = cnt_q + c_ONE_P;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    s_ready_o = 1'b0;
    w_m_valid = 1'b0;
    m_sof_o   = 1'b0;
    m_eol_o   = 1'b0;
    m_data_o  = '0;
    case (state_q)
      c_FILL: s_ready_o = 1'b1;
      c_PRE: begin
        w_m_valid = 1'b1;
        m_data_o  = w_mirror;
        m_sof_o   = (line_q == '0) && (cnt_q == '0);
      end
      c_HEAD: begin
        w_m_valid = 1'b1;
        m_data_o  = hist_q[w_idx];
      end
      c_PASS: begin
        s_ready_o = m_ready_i;
        w_m_valid = s_valid_i;
        m_data_o  = s_data_i;
      end
      c_POST: begin
        w_m_valid = 1'b1;
        m_data_o  = w_mirror;
        m_eol_o   = (cnt_q == c_E_M1_P);
      end
      default: ;
    endcase
  end

  assign m_valid_o = w_m_valid;
  assign busy_o    = (state_q != c_IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;

`ifdef DWT_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == c_IDLE) && cfg_start_i && !w_cfg_bad) begin
      perf_d = '0;
    end else if (w_m_valid && !m_ready_i && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_stall_o = perf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dwt97_line_sequencer.sv
`default_nettype none
// Testbench for dwt97_line_sequencer: random traffic against a queue-based
// model of the extended-line output order.
module tb_dwt97_line_sequencer;

  localparam int DW  = 16;
  localparam int MSS = 512;
  localparam int E   = 2;
  localparam int PW  = $clog2(MSS/2) + 1;
  localparam int LW  = $clog2(MSS) + 1;
  localparam int BW  = 2 * DW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cfg_start_i = 1'b0;
  logic [PW-1:0] cfg_pairs_i = '0;
  logic [LW-1:0] cfg_lines_i = '0;
  logic          busy_o, done_o, err_o;
  logic          s_ready_o;
  logic          s_valid_i = 1'b0;
  logic [BW-1:0] s_data_i = '0;
  logic          m_ready_i = 1'b0;
  logic          m_valid_o, m_sof_o, m_eol_o;
  logic [BW-1:0] m_data_o;
`ifdef DWT_SEQ_PERF_EN
  logic [31:0]   perf_stall_o;
`endif

  dwt97_line_sequencer #(
    .DataWidth(DW), .MaximumSideSize(MSS), .ExtPairs(E)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_start_i(cfg_start_i),
    .cfg_pairs_i(cfg_pairs_i), .cfg_lines_i(cfg_lines_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
`ifdef DWT_SEQ_PERF_EN
    .perf_stall_o(perf_stall_o),
`endif
    .s_ready_o(s_ready_o), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .m_ready_i(m_ready_i), .m_valid_o(m_valid_o), .m_sof_o(m_sof_o),
    .m_eol_o(m_eol_o), .m_data_o(m_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BW-1:0] in_q [$];
  logic [BW+1:0] exp_q [$];  // {sof, eol, data}

  // Reference: each line becomes mirror-before, the line itself, mirror-after.
  function automatic void build(int P, int L, bit seq);
    logic [BW-1:0] ln [$];
    for (int l = 0; l < L; l++) begin
      ln.delete();
      for (int j = 0; j < P; j++) begin
        if (seq) ln.push_back({DW'(2*j+1), DW'(2*j)});
        else     ln.push_back(BW'($urandom));
        in_q.push_back(ln[j]);
      end
      for (int k = E; k >= 1; k--)
        exp_q.push_back({(l == 0 && k == E), 1'b0, ln[k-1][BW-1:DW], ln[k][DW-1:0]});
      for (int j = 0; j < P; j++)
        exp_q.push_back({2'b00, ln[j]});
      for (int k = 1; k <= E; k++)
        exp_q.push_back({1'b0, (k == E), ln[P-k-1][BW-1:DW], ln[P-k][DW-1:0]});
    end
  endfunction

  task automatic start_frame(input int P, input int L);
    @(negedge clk_i);
    cfg_start_i = 1'b1;
    cfg_pairs_i = PW'(P);
    cfg_lines_i = LW'(L);
    @(negedge clk_i);
    cfg_start_i = 1'b0;
    cfg_pairs_i = PW'($urandom);
    cfg_lines_i = LW'($urandom);
  endtask

  task automatic run_frame(input int vpct, input int rpct, input int inject_at,
                           input int abort_at, output bit aborted);
    int cyc = 0, outs = 0, stalls = 0;
    bit prev_stall = 0, taken = 0;
    logic [BW+1:0] prev = '0;
    aborted = 0;
    while (1) begin
      @(negedge clk_i);
      if (taken) begin
        void'(in_q.pop_front());
        s_valid_i = 1'b0;
        taken = 0;
      end
      if (cyc == inject_at) begin
        cfg_start_i = 1'b1; cfg_pairs_i = PW'(7); cfg_lines_i = LW'(3);
      end else begin
        cfg_start_i = 1'b0;
      end
      if (!s_valid_i && in_q.size() > 0 && $urandom_range(99) < vpct) begin
        s_valid_i = 1'b1;
        s_data_i  = in_q[0];
      end
      m_ready_i = ($urandom_range(99) < rpct);
      #1;
      if (prev_stall) begin
        n_checks++;
        if (!m_valid_o || {m_sof_o, m_eol_o, m_data_o} !== prev) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0b %h required valid=1 %h", m_valid_o,
                   {m_sof_o, m_eol_o, m_data_o}, prev);
        end
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev = {m_sof_o, m_eol_o, m_data_o};
      if (prev_stall) stalls++;
      n_checks++;
      if (done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL done_early: got done=%0b required 0 at output %0d", done_o, outs);
      end
      if (m_valid_o && m_ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_output: got %h required no output", m_data_o);
        end else begin
          if ({m_sof_o, m_eol_o, m_data_o} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL out_pair[%0d]: got sof/eol/data %h required %h", outs,
                     {m_sof_o, m_eol_o, m_data_o}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        outs++;
      end
      if (s_valid_i && s_ready_o) taken = 1;
      if (abort_at > 0 && outs == abort_at) begin
        aborted = 1;
        return;
      end
      if (exp_q.size() == 0) break;
      cyc++;
      if (cyc > 4000) begin
        n_checks++; n_fail++;
        $display("FAIL timeout: got %0d outputs left required 0", exp_q.size());
        exp_q.delete();
        break;
      end
    end
    if (taken) void'(in_q.pop_front());
    @(negedge clk_i);
    cfg_start_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0;
    #1;
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || in_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_end: got done=%0b busy=%0b unread=%0d required 1 0 0",
               done_o, busy_o, in_q.size());
    end
`ifdef DWT_SEQ_PERF_EN
    n_checks++;
    if (perf_stall_o !== 32'(stalls)) begin
      n_fail++;
      $display("FAIL perf_stall: got %0d required %0d", perf_stall_o, stalls);
    end
`endif
    @(negedge clk_i); #1;
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%0b required 0", done_o);
    end
    in_q.delete();
  endtask

  task automatic check_idle_zero(input string name);
    n_checks++;
    if ({busy_o, done_o, err_o, s_ready_o, m_valid_o, m_sof_o, m_eol_o, m_data_o} !== '0) begin
      n_fail++;
      $display("FAIL %s: got busy=%0b done=%0b err=%0b rdy=%0b vld=%0b sof=%0b eol=%0b data=%h required all 0",
               name, busy_o, done_o, err_o, s_ready_o, m_valid_o, m_sof_o, m_eol_o, m_data_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1 check_idle_zero("reset_state");
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1 check_idle_zero("idle_after_reset");
  endtask

  task automatic test_basic_line();
    bit ab;
    build(4, 1, 1);
    start_frame(4, 1);
    run_frame(100, 100, -1, 0, ab);
  endtask

  task automatic test_min_line();
    bit ab;
    build(3, 2, 1);
    start_frame(3, 2);
    run_frame(100, 100, -1, 0, ab);
  endtask

  task automatic test_backpressure();
    bit ab;
    build(4, 1, 1);
    start_frame(4, 1);
    run_frame(100, 50, -1, 0, ab);
    build(9, 3, 0);
    start_frame(9, 3);
    run_frame(60, 50, -1, 0, ab);
    build(MSS/2, 1, 0);
    start_frame(MSS/2, 1);
    run_frame(90, 85, -1, 0, ab);
  endtask

  task automatic test_bad_config();
    bit ab;
    int bp [3] = '{E, 4, MSS/2 + 1};
    int bl [3] = '{1, 0, 1};
    for (int i = 0; i < 3; i++) begin
      start_frame(bp[i], bl[i]);
      #1;
      n_checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0 || s_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_cfg[%0d]: got err=%0b busy=%0b rdy=%0b required 1 0 0",
                 i, err_o, busy_o, s_ready_o);
      end
    end
    build(5, 1, 0);
    start_frame(5, 1);
    #1;
    n_checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_clear: got err=%0b busy=%0b required 0 1", err_o, busy_o);
    end
    run_frame(80, 80, -1, 0, ab);
  endtask

  task automatic test_reset_mid_frame();
    bit ab;
    build(8, 3, 0);
    start_frame(8, 3);
    run_frame(100, 70, -1, (8 + 2*E) + 6, ab);
    n_checks++;
    if (!ab) begin
      n_fail++;
      $display("FAIL abort_point: got frame end required abort in line 1");
    end
    @(negedge clk_i);
    s_valid_i = 1'b1; m_ready_i = 1'b1;
    rst_ni = 1'b0;
    #1 check_idle_zero("reset_mid_frame");
    @(negedge clk_i);
    s_valid_i = 1'b0; m_ready_i = 1'b0; cfg_start_i = 1'b0;
    rst_ni = 1'b1;
    in_q.delete();
    exp_q.delete();
    build(6, 2, 0);
    start_frame(6, 2);
    run_frame(75, 75, -1, 0, ab);
  endtask

  task automatic test_start_while_busy();
    bit ab;
    build(4, 2, 0);
    start_frame(4, 2);
    run_frame(80, 80, 5, 0, ab);
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_min_line();
    test_backpressure();
    test_bad_config();
    test_reset_mid_frame();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
